// File: rtl/chip_bridge_pkg.sv
// chip_bridge_pkg: shared widths, channel encodings and channel decode for the chip bridge
package chip_bridge_pkg;
  localparam int NUM_CH = 3;
  localparam int WORD_W = 32;
  localparam int FLIT_W = 64;
  typedef enum logic [1:0] {
    CH_IDLE = 2'b00,
    CH_NOC1 = 2'b01,
    CH_NOC2 = 2'b10,
    CH_NOC3 = 2'b11
  } ch_e;
  function automatic logic [NUM_CH-1:0] ch_decode(input logic [1:0] ch);
    return {ch == CH_NOC3, ch == CH_NOC2, ch == CH_NOC1};
  endfunction
endpackage

// File: rtl/chip_bridge_rx_chan.sv
// chip_bridge_rx_chan: one channel's word FIFO, flit pairing, credit return and overflow detect
module chip_bridge_rx_chan
  import chip_bridge_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              io_clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] data,
  input  logic              rdy,
  output logic [FLIT_W-1:0] flit,
  output logic              val,
  output logic              credit,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, pending, pending_next;
  logic pop, full, accept;
  assign val = count >= CW'(2);
  assign pop = val & rdy;
  assign full = count == CW'(DEPTH);
  assign accept = push & (!full | pop);
  // pending already includes the credit currently on the wire, so it is retired here
  assign pending_next = pending + (pop ? CW'(2) : CW'(0)) - CW'(credit);
  assign flit = val ? {mem[rd_ptr + AW'(1)], mem[rd_ptr]} : '0;
  always_ff @(posedge io_clk) begin
    if (accept) mem[wr_ptr] <= data;
  end
  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      credit   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= accept ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + AW'(2) : rd_ptr;
      count    <= count + CW'(accept) - (pop ? CW'(2) : CW'(0));
      pending  <= pending_next;
      credit   <= pending_next != '0;
      overflow <= overflow | (push & full & !pop);
    end
  end
endmodule

// File: rtl/chip_bridge_rx.sv
// chip_bridge_rx: decodes chip words onto three independent channels and returns credits
module chip_bridge_rx
  import chip_bridge_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              io_clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] chip_intf_data,
  input  logic [1:0]        chip_intf_channel,
  output logic [NUM_CH-1:0] chip_intf_credit_back,
  output logic [FLIT_W-1:0] noc1_out_data,
  output logic              noc1_out_val,
  input  logic              noc1_out_rdy,
  output logic [FLIT_W-1:0] noc2_out_data,
  output logic              noc2_out_val,
  input  logic              noc2_out_rdy,
  output logic [FLIT_W-1:0] noc3_out_data,
  output logic              noc3_out_val,
  input  logic              noc3_out_rdy,
  output logic              overflow_err
);
  logic [NUM_CH-1:0] push, rdy, val, ovf;
  logic [FLIT_W-1:0] flit [NUM_CH];
  assign push = ch_decode(chip_intf_channel);
  assign rdy = {noc3_out_rdy, noc2_out_rdy, noc1_out_rdy};
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    chip_bridge_rx_chan #(.DEPTH(DEPTH)) u_chan (
      .io_clk   (io_clk),
      .rst_n    (rst_n),
      .push     (push[c]),
      .data     (chip_intf_data),
      .rdy      (rdy[c]),
      .flit     (flit[c]),
      .val      (val[c]),
      .credit   (chip_intf_credit_back[c]),
      .overflow (ovf[c])
    );
  end
  assign noc1_out_data = flit[0];
  assign noc2_out_data = flit[1];
  assign noc3_out_data = flit[2];
  assign noc1_out_val = val[0];
  assign noc2_out_val = val[1];
  assign noc3_out_val = val[2];
  assign overflow_err = |ovf;
endmodule

// File: tb/tb_chip_bridge_rx.sv
// tb_chip_bridge_rx: vector table plus scoreboarded sequences for chip_bridge_rx
module tb_chip_bridge_rx;
  logic        io_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] chip_intf_data = '0;
  logic [1:0]  chip_intf_channel = '0;
  logic [2:0]  chip_intf_credit_back;
  logic [2:0]  val_v;
  logic [2:0]  rdy_v = '0;
  logic [63:0] dat [3];
  logic        overflow_err;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [3][$];
  int cred [3] = '{0, 0, 0};
  int base [3] = '{0, 0, 0};
  logic [63:0] held [3];
  bit hold [3] = '{0, 0, 0};
  typedef struct {
    logic [1:0]  ch;
    logic [31:0] d;
    logic [2:0]  val;
    logic [2:0]  cr;
  } vec_t;
  vec_t vt [9];

  chip_bridge_rx #(.DEPTH(8)) dut (
    .io_clk                (io_clk),
    .rst_n                 (rst_n),
    .chip_intf_data        (chip_intf_data),
    .chip_intf_channel     (chip_intf_channel),
    .chip_intf_credit_back (chip_intf_credit_back),
    .noc1_out_data         (dat[0]),
    .noc1_out_val          (val_v[0]),
    .noc1_out_rdy          (rdy_v[0]),
    .noc2_out_data         (dat[1]),
    .noc2_out_val          (val_v[1]),
    .noc2_out_rdy          (rdy_v[1]),
    .noc3_out_data         (dat[2]),
    .noc3_out_val          (val_v[2]),
    .noc3_out_rdy          (rdy_v[2]),
    .overflow_err          (overflow_err)
  );

  always #5 io_clk = ~io_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // samples at the falling edge what the next rising edge will act on, then steps past it
  task automatic tick();
    @(negedge io_clk);
    for (int k = 0; k < 3; k++) begin
      if (rst_n) begin
        if (chip_intf_credit_back[k]) cred[k]++;
        if (hold[k]) chk("hold_stable", dat[k], held[k]);
        hold[k] = val_v[k] && !rdy_v[k];
        held[k] = dat[k];
        if (val_v[k] && rdy_v[k]) begin
          if (exp_q[k].size() < 2) chk("sb_words_avail", 64'(exp_q[k].size()), 64'd2);
          else begin
            chk("flit_data", dat[k], {exp_q[k][1], exp_q[k][0]});
            void'(exp_q[k].pop_front());
            void'(exp_q[k].pop_front());
          end
        end
      end else hold[k] = 0;
    end
    @(posedge io_clk);
    #1;
  endtask

  task automatic send(input int k, input logic [31:0] w);
    chip_intf_channel = 2'(k + 1);
    chip_intf_data = w;
    exp_q[k].push_back(w);
    tick();
    chip_intf_channel = 2'b00;
  endtask

  task automatic idle(input int n);
    chip_intf_channel = 2'b00;
    repeat (n) tick();
  endtask

  task automatic snap();
    for (int k = 0; k < 3; k++) base[k] = cred[k];
  endtask

  task automatic chk_cred(input int e0, input int e1, input int e2);
    chk("credits_ch1", 64'(cred[0] - base[0]), 64'(e0));
    chk("credits_ch2", 64'(cred[1] - base[1]), 64'(e1));
    chk("credits_ch3", 64'(cred[2] - base[2]), 64'(e2));
  endtask

  task automatic chk_empty();
    for (int k = 0; k < 3; k++) chk("sb_drained", 64'(exp_q[k].size()), 64'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_val", 64'(val_v), 64'd0);
    chk("rst_credit", 64'(chip_intf_credit_back), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    for (int k = 0; k < 3; k++) chk("rst_data", dat[k], 64'd0);
  endtask

  task automatic do_reset();
    chip_intf_channel = 2'b00;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      hold[k] = 0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{2'd1, 32'h1111_1111, 3'b000, 3'b000};
    vt[1] = '{2'd1, 32'h2222_2222, 3'b001, 3'b000};
    vt[2] = '{2'd2, 32'haaaa_0001, 3'b000, 3'b001};
    vt[3] = '{2'd2, 32'haaaa_0002, 3'b010, 3'b001};
    vt[4] = '{2'd3, 32'hbbbb_0001, 3'b000, 3'b010};
    vt[5] = '{2'd3, 32'hbbbb_0002, 3'b100, 3'b010};
    vt[6] = '{2'd0, 32'h0,         3'b000, 3'b100};
    vt[7] = '{2'd0, 32'h0,         3'b000, 3'b100};
    vt[8] = '{2'd0, 32'h0,         3'b000, 3'b000};
    repeat (2) tick();
    do_reset();
    // basic flits on every channel, cycle-exact val and credit timing
    snap();
    rdy_v = 3'b111;
    for (int i = 0; i < 9; i++) begin
      chip_intf_channel = vt[i].ch;
      chip_intf_data = vt[i].d;
      if (vt[i].ch != 2'd0) exp_q[vt[i].ch - 1].push_back(vt[i].d);
      tick();
      chk("tbl_val", 64'(val_v), 64'(vt[i].val));
      chk("tbl_credit", 64'(chip_intf_credit_back), 64'(vt[i].cr));
    end
    idle(3);
    chk_cred(2, 2, 2);
    chk_empty();
    // fill channel 2 to full, then overflow it
    snap();
    rdy_v = 3'b101;
    for (int i = 0; i < 8; i++) send(1, 32'h2000_0000 + i);
    chk("full_val2", 64'(val_v[1]), 64'd1);
    chk("full_no_ovf", 64'(overflow_err), 64'd0);
    chip_intf_channel = 2'd2;
    chip_intf_data = 32'hdead_beef;
    tick();
    chip_intf_channel = 2'd0;
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_first_flit", dat[1], 64'h2000_0001_2000_0000);
    idle(3);
    chk_cred(0, 0, 0);
    rdy_v = 3'b111;
    idle(10);
    chk("ovf_sticky", 64'(overflow_err), 64'd1);
    chk_cred(0, 8, 0);
    chk_empty();
    do_reset();
    // full channel 3 with simultaneous pop and push
    snap();
    rdy_v = 3'b011;
    for (int i = 0; i < 8; i++) send(2, 32'h3000_0000 + i);
    chk("full_val3", 64'(val_v[2]), 64'd1);
    rdy_v = 3'b111;
    send(2, 32'h3000_0008);
    chk("pop_push_no_ovf", 64'(overflow_err), 64'd0);
    idle(5);
    chk("odd_word_left", 64'(val_v[2]), 64'd0);
    send(2, 32'h3000_0009);
    chk("last_pair_val", 64'(val_v[2]), 64'd1);
    idle(6);
    chk_cred(0, 0, 10);
    chk_empty();
    // interleaved channels
    snap();
    for (int i = 0; i < 12; i++) send(i % 3, $urandom);
    idle(6);
    chk_cred(4, 4, 4);
    chk_empty();
    // backpressure on channel 1 across several pointer wraps
    snap();
    for (int i = 0; i < 40; i++) begin
      rdy_v[0] = (i % 2) == 1;
      send(0, 32'h4000_0000 + i);
    end
    rdy_v = 3'b111;
    idle(8);
    chk_cred(40, 0, 0);
    chk("bp_no_ovf", 64'(overflow_err), 64'd0);
    chk_empty();
    // reset with 5 words buffered and 2 credits pending
    rdy_v = 3'b110;
    for (int i = 0; i < 7; i++) send(0, 32'h5000_0000 + i);
    rdy_v = 3'b111;
    tick();
    do_reset();
    snap();
    send(0, 32'h6000_0000);
    send(0, 32'h6000_0001);
    chk("fresh_val", 64'(val_v[0]), 64'd1);
    chk("fresh_data", dat[0], 64'h6000_0001_6000_0000);
    idle(6);
    chk_cred(2, 0, 0);
    chk_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
